// File: rtl/fsm_obs_pkg.sv
// Shared definitions for the fsm_obs_tracker observer: state indices, one-cold
// codes, candidate-set type and helpers that derive lock status from a set.
package fsm_obs_pkg;

  localparam int NUM_ST = 5;

  localparam int S0_IDX = 0;
  localparam int S1_IDX = 1;
  localparam int S2_IDX = 2;
  localparam int S3_IDX = 3;
  localparam int S4_IDX = 4;

  typedef logic [NUM_ST-1:0] cand_t;

  // Candidate-set bit for each state (bit i = Si).
  localparam cand_t S0_BIT = 5'b00001;
  localparam cand_t S1_BIT = 5'b00010;
  localparam cand_t S2_BIT = 5'b00100;
  localparam cand_t S3_BIT = 5'b01000;
  localparam cand_t S4_BIT = 5'b10000;

  // One-cold state codes presented on cur_st.
  localparam cand_t S0_ST = 5'b01111;
  localparam cand_t S1_ST = 5'b10111;
  localparam cand_t S2_ST = 5'b11011;
  localparam cand_t S3_ST = 5'b11101;
  localparam cand_t S4_ST = 5'b11110;

  localparam cand_t CAND_ALL = 5'b11111;

  function automatic logic is_single(input cand_t c);
    return $countones(c) == 1;
  endfunction

  function automatic cand_t one_cold(input cand_t c);
    cand_t code;
    code = CAND_ALL;
    case (c)
      S0_BIT:  code = S0_ST;
      S1_BIT:  code = S1_ST;
      S2_BIT:  code = S2_ST;
      S3_BIT:  code = S3_ST;
      S4_BIT:  code = S4_ST;
      default: code = CAND_ALL;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/fsm_obs_step.sv
// One controller state's contribution: successor set and implied a/b (with
// known flags) for the observed (m,n). All outputs are zero when act is low.
module fsm_obs_step
  import fsm_obs_pkg::*;
#(
  parameter int ST_IDX = S0_IDX
) (
  input  logic  act,
  input  logic  m_obs,
  input  logic  n_obs,
  output cand_t nxt,
  output logic  a_val,
  output logic  a_kn,
  output logic  b_val,
  output logic  b_kn
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    nxt   = '0;
    a_val = 1'b0;
    a_kn  = 1'b0;
    b_val = 1'b0;
    b_kn  = 1'b0;
    if (act) begin
      case (ST_IDX)
        S0_IDX: begin
          case ({m_obs, n_obs})
            2'b00: begin nxt = S0_BIT; a_kn = 1'b1; end
            2'b10: begin nxt = S4_BIT; a_kn = 1'b1; a_val = 1'b1; b_kn = 1'b1; b_val = 1'b1; end
            2'b01: begin nxt = S1_BIT; a_kn = 1'b1; a_val = 1'b1; b_kn = 1'b1; end
            default: ;
          endcase
        end
        S1_IDX: begin
          if (m_obs && n_obs) nxt = S2_BIT;
        end
        S2_IDX: begin
          case ({m_obs, n_obs})
            2'b01: begin nxt = S4_BIT; a_kn = 1'b1; end
            2'b10: begin nxt = S3_BIT; a_kn = 1'b1; a_val = 1'b1; end
            default: ;
          endcase
        end
        S3_IDX: begin
          case ({m_obs, n_obs})
            2'b00: begin nxt = S3_BIT | S4_BIT; a_kn = 1'b1; a_val = 1'b1; end
            2'b11: begin nxt = S3_BIT | S0_BIT; a_kn = 1'b1; end
            default: ;
          endcase
        end
        default: begin
          case ({m_obs, n_obs})
            2'b01: begin nxt = S4_BIT; b_kn = 1'b1; end
            2'b11: begin nxt = S1_BIT; b_kn = 1'b1; b_val = 1'b1; end
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/fsm_obs_tracker.sv
// Passive observer tracking the candidate state set of the a/b -> m/n Mealy
// controller. Define FSM_OBS_RESYNC_EN to re-acquire after an error instead of
// latching err until reset.
module fsm_obs_tracker
  import fsm_obs_pkg::*;
#(
  parameter bit INIT_ALL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              obs_vld,
  input  logic              m_obs,
  input  logic              n_obs,
  output logic [NUM_ST-1:0] cand,
  output logic              locked,
  output logic [NUM_ST-1:0] cur_st,
  output logic              a_rec,
  output logic              a_known,
  output logic              b_rec,
  output logic              b_known,
  output logic              err
);

  localparam cand_t CAND_INIT = INIT_ALL ? CAND_ALL : S0_BIT;

  cand_t             step_nxt [NUM_ST];
  logic [NUM_ST-1:0] hit, a_val, a_kn, b_val, b_kn;

  for (genvar i = 0; i < NUM_ST; i++) begin : g_step
    fsm_obs_step #(.ST_IDX(i)) u_step (
      .act   (cand[i]),
      .m_obs (m_obs),
      .n_obs (n_obs),
      .nxt   (step_nxt[i]),
      .a_val (a_val[i]),
      .a_kn  (a_kn[i]),
      .b_val (b_val[i]),
      .b_kn  (b_kn[i])
    );
    assign hit[i] = |step_nxt[i];
  end

  cand_t union_nxt;
  always_comb begin
    union_nxt = '0;
    for (int i = 0; i < NUM_ST; i++) union_nxt |= step_nxt[i];
  end

  // A value is known only when no contributing transition leaves it open and
  // the known ones all agree.
  logic a_one, a_zero, a_open, b_one, b_zero, b_open;
  assign a_one  = |(hit & a_kn & a_val);
  assign a_zero = |(hit & a_kn & ~a_val);
  assign a_open = |(hit & ~a_kn);
  assign b_one  = |(hit & b_kn & b_val);
  assign b_zero = |(hit & b_kn & ~b_val);
  assign b_open = |(hit & ~b_kn);

  logic accept;
`ifdef FSM_OBS_RESYNC_EN
  localparam cand_t CAND_ON_ERR = CAND_ALL;
  assign accept = obs_vld;
`else
  localparam cand_t CAND_ON_ERR = '0;
  assign accept = obs_vld && !err;
`endif

  cand_t cand_d;
  logic  a_rec_d, a_known_d, b_rec_d, b_known_d, err_d;

  always_comb begin
    cand_d    = cand;
    a_rec_d   = a_rec;
    a_known_d = a_known;
    b_rec_d   = b_rec;
    b_known_d = b_known;
`ifdef FSM_OBS_RESYNC_EN
    err_d     = 1'b0;
`else
    err_d     = err;
`endif
    if (accept) begin
      if (union_nxt == '0) begin
        cand_d    = CAND_ON_ERR;
        err_d     = 1'b1;
        a_rec_d   = 1'b0;
        a_known_d = 1'b0;
        b_rec_d   = 1'b0;
        b_known_d = 1'b0;
      end else begin
        cand_d    = union_nxt;
        a_known_d = !a_open && (a_one != a_zero);
        a_rec_d   = a_known_d && a_one;
        b_known_d = !b_open && (b_one != b_zero);
        b_rec_d   = b_known_d && b_one;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cand    <= CAND_INIT;
      locked  <= is_single(CAND_INIT);
      cur_st  <= one_cold(CAND_INIT);
      a_rec   <= 1'b0;
      a_known <= 1'b0;
      b_rec   <= 1'b0;
      b_known <= 1'b0;
      err     <= 1'b0;
    end else begin
      cand    <= cand_d;
      locked  <= is_single(cand_d);
      cur_st  <= one_cold(cand_d);
      a_rec   <= a_rec_d;
      a_known <= a_known_d;
      b_rec   <= b_rec_d;
      b_known <= b_known_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_fsm_obs_tracker.sv
// Scoreboard bench for fsm_obs_tracker: two instances (INIT_ALL=0/1) share the
// stimulus; a set-level reference model queues expectations, a monitor checks.
module tb_fsm_obs_tracker;

`ifdef FSM_OBS_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] cand;
    logic       locked;
    logic [4:0] cur_st;
    logic       a_rec;
    logic       a_known;
    logic       b_rec;
    logic       b_known;
    logic       err;
  } obs_t;
  typedef obs_t [1:0] obs_pair_t;

  logic clk = 1'b0;
  logic rst_b = 1'b0, obs_vld = 1'b0, m_obs = 1'b0, n_obs = 1'b0;
  logic [4:0] cand_o [2];
  logic [4:0] cur_o [2];
  logic       locked_o [2], a_rec_o [2], a_kn_o [2], b_rec_o [2], b_kn_o [2], err_o [2];

  always #5 clk = ~clk;

  fsm_obs_tracker #(.INIT_ALL(1'b0)) dut0 (
    .clk(clk), .rst_b(rst_b), .obs_vld(obs_vld), .m_obs(m_obs), .n_obs(n_obs),
    .cand(cand_o[0]), .locked(locked_o[0]), .cur_st(cur_o[0]),
    .a_rec(a_rec_o[0]), .a_known(a_kn_o[0]), .b_rec(b_rec_o[0]), .b_known(b_kn_o[0]),
    .err(err_o[0])
  );

  fsm_obs_tracker #(.INIT_ALL(1'b1)) dut1 (
    .clk(clk), .rst_b(rst_b), .obs_vld(obs_vld), .m_obs(m_obs), .n_obs(n_obs),
    .cand(cand_o[1]), .locked(locked_o[1]), .cur_st(cur_o[1]),
    .a_rec(a_rec_o[1]), .a_known(a_kn_o[1]), .b_rec(b_rec_o[1]), .b_known(b_kn_o[1]),
    .err(err_o[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  obs_pair_t exp_q[$];

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got cand=%b lk=%b cur=%b a=%b/%b b=%b/%b err=%b, want cand=%b lk=%b cur=%b a=%b/%b b=%b/%b err=%b",
               name, $time, got.cand, got.locked, got.cur_st, got.a_known, got.a_rec,
               got.b_known, got.b_rec, got.err, want.cand, want.locked, want.cur_st,
               want.a_known, want.a_rec, want.b_known, want.b_rec, want.err);
    end
  endtask

  // Reference transition table: next set and implied a/b (2 = unknown).
  task automatic trans(input int s, input logic [1:0] mn,
                       output logic [4:0] nx, output int a, output int b);
    nx = 5'b0; a = 2; b = 2;
    case (s)
      0: case (mn)
           2'b00: begin nx = 5'b00001; a = 0; end
           2'b10: begin nx = 5'b10000; a = 1; b = 1; end
           2'b01: begin nx = 5'b00010; a = 1; b = 0; end
           default: ;
         endcase
      1: if (mn == 2'b11) nx = 5'b00100;
      2: case (mn)
           2'b01: begin nx = 5'b10000; a = 0; end
           2'b10: begin nx = 5'b01000; a = 1; end
           default: ;
         endcase
      3: case (mn)
           2'b00: begin nx = 5'b11000; a = 1; end
           2'b11: begin nx = 5'b01001; a = 0; end
           default: ;
         endcase
      default: case (mn)
           2'b01: begin nx = 5'b10000; b = 0; end
           2'b11: begin nx = 5'b00010; b = 1; end
           default: ;
         endcase
    endcase
  endtask

  logic [4:0] m_cand [2];
  logic       m_err [2], m_arec [2], m_akn [2], m_brec [2], m_bkn [2];

  task automatic model_step(input logic r, input logic v, input logic m, input logic n);
    logic [4:0] nx, tn;
    int ta, tb;
    bit a0, a1, ax, b0, b1, bx;
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        m_cand[k] = (k == 1) ? 5'b11111 : 5'b00001;
        m_err[k] = 0; m_arec[k] = 0; m_akn[k] = 0; m_brec[k] = 0; m_bkn[k] = 0;
      end else if (v && (RESYNC || !m_err[k])) begin
        nx = 5'b0; a0 = 0; a1 = 0; ax = 0; b0 = 0; b1 = 0; bx = 0;
        for (int s = 0; s < 5; s++) begin
          if (m_cand[k][s]) begin
            trans(s, {m, n}, tn, ta, tb);
            if (tn != 5'b0) begin
              nx |= tn;
              if (ta == 0) a0 = 1; else if (ta == 1) a1 = 1; else ax = 1;
              if (tb == 0) b0 = 1; else if (tb == 1) b1 = 1; else bx = 1;
            end
          end
        end
        if (nx == 5'b0) begin
          m_cand[k] = RESYNC ? 5'b11111 : 5'b00000;
          m_err[k] = 1; m_arec[k] = 0; m_akn[k] = 0; m_brec[k] = 0; m_bkn[k] = 0;
        end else begin
          m_cand[k] = nx;
          m_err[k]  = 0;
          m_akn[k]  = !ax && (a0 != a1);
          m_arec[k] = m_akn[k] && a1;
          m_bkn[k]  = !bx && (b0 != b1);
          m_brec[k] = m_bkn[k] && b1;
        end
      end else if (RESYNC) begin
        m_err[k] = 0;
      end
    end
  endtask

  function automatic obs_t model_out(input int k);
    obs_t o;
    o.cand    = m_cand[k];
    o.locked  = ($countones(m_cand[k]) == 1);
    o.cur_st  = 5'b11111;
    for (int s = 0; s < 5; s++)
      if (o.locked && m_cand[k][s]) o.cur_st = 5'b11111 & ~(5'b10000 >> s);
    o.a_rec   = m_arec[k];
    o.a_known = m_akn[k];
    o.b_rec   = m_brec[k];
    o.b_known = m_bkn[k];
    o.err     = m_err[k];
    return o;
  endfunction

  task automatic push_expect();
    obs_pair_t e;
    e[0] = model_out(0);
    e[1] = model_out(1);
    exp_q.push_back(e);
  endtask

  // Inputs are applied 1 time unit after an edge; the model advances at the
  // edge that samples them.
  task automatic drive(input logic r, input logic v, input logic [1:0] mn);
    rst_b = r; obs_vld = v; m_obs = mn[1]; n_obs = mn[0];
    @(posedge clk);
    model_step(r, v, mn[1], mn[0]);
    push_expect();
    #1;
  endtask

  task automatic reset_glitch();
    obs_vld = 1'b0; rst_b = 1'b0;
    #3 rst_b = 1'b1;
    @(posedge clk);
    model_step(1'b1, 1'b0, m_obs, n_obs);
    push_expect();
    #1;
  endtask

  always @(negedge clk) begin
    obs_pair_t e;
    obs_t got;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 2; k++) begin
        got = '{cand: cand_o[k], locked: locked_o[k], cur_st: cur_o[k],
                a_rec: a_rec_o[k], a_known: a_kn_o[k], b_rec: b_rec_o[k],
                b_known: b_kn_o[k], err: err_o[k]};
        check(k == 0 ? "out_init0" : "out_init1", got, e[k]);
      end
    end
  end

  initial begin
    logic [1:0] lock_seq [5];
    lock_seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};

    drive(1'b0, 1'b0, 2'b00);
    drive(1'b0, 1'b1, 2'b11);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, lock_seq[i]);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 2'($urandom_range(0, 3)));

    // Lock on S3, then a reset edge with a valid sample, then a glitch reset.
    drive(1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b1, 2'b01);
    drive(1'b1, 1'b1, 2'b11);
    drive(1'b1, 1'b1, 2'b10);
    drive(1'b0, 1'b1, 2'b00);
    drive(1'b1, 1'b1, 2'b10);
    reset_glitch();
    drive(1'b1, 1'b0, 2'b00);

    // Inconsistent sample from S0, then more samples.
    drive(1'b0, 1'b0, 2'b00);
    drive(1'b1, 1'b1, 2'b11);
    drive(1'b1, 1'b1, 2'b10);
    drive(1'b1, 1'b1, 2'b00);
    drive(1'b1, 1'b1, 2'b00);
    drive(1'b1, 1'b0, 2'b00);

    for (int i = 0; i < 800; i++)
      drive(($urandom_range(0, 24) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)));

    repeat (2) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_obs_tracker.md
Name: fsm_obs_tracker

Overview:
- Passive observer ("receiver side") for the 5-state Mealy controller with inputs a/b and outputs m/n.
- Samples the controller's (m,n) output stream and tracks the set of controller states consistent with the history.
- Reconstructs the a/b inputs wherever they are uniquely implied by the observations.
- Flags an error when no controller state can explain the observed stream; used as an in-system monitor/checker beside the controller.

Parameters:
- INIT_ALL, 0: 0 = candidate set after reset is {S0} (controller reset state); 1 = all five states (observer attached mid-run).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_b  input  1  synchronous, active-low reset; sampled on clk rising edge
- obs_vld  input  1  qualifies m_obs/n_obs for this cycle
- m_obs  input  1  observed controller output m
- n_obs  input  1  observed controller output n
- cand  output  5  candidate state set, bit i = Si possible (positive logic)
- locked  output  1  cand has exactly one bit set
- cur_st  output  5  one-cold code of the locked state; 5'b11111 when not locked
- a_rec  output  1  reconstructed a for the last accepted sample
- a_known  output  1  a_rec is valid
- b_rec  output  1  reconstructed b for the last accepted sample
- b_known  output  1  b_rec is valid
- err  output  1  observation inconsistent with every candidate state

Behaviour:
- All outputs are registered; one cycle of latency from the accepted sample to the updated outputs.
- Reset (rst_b=0 at a clk edge):
  - cand = 5'b00001 (INIT_ALL=0) or 5'b11111 (INIT_ALL=1).
  - locked and cur_st follow cand.
  - a_rec = b_rec = a_known = b_known = err = 0.
- obs_vld=0: all state and outputs hold.
- Per-state transition map, written (mn) -> next set [a,b implied, x = unknown]:
  - S0: 00 -> {S0} [0,x]; 10 -> {S4} [1,1]; 01 -> {S1} [1,0]; 11 -> none.
  - S1: 11 -> {S2} [x,x]; any other value -> none.
  - S2: 01 -> {S4} [0,x]; 10 -> {S3} [1,x]; 00 or 11 -> none.
  - S3: 00 -> {S3,S4} [1,x]; 11 -> {S3,S0} [0,x]; 01 or 10 -> none.
  - S4: 01 -> {S4} [x,0]; 11 -> {S1} [x,1]; 00 or 10 -> none.
- Next cand = union of the next sets over all set bits of the current cand.
- a_known = 1 only if at least one transition contributes and every contributing transition gives the same known a; a_rec is that value, else 0. Same rule for b.
- locked = popcount(cand)==1. cur_st: S0=01111, S1=10111, S2=11011, S3=11101, S4=11110.
- Empty result:
  - err=1; cand=0; locked=0; known flags cleared.
  - err is sticky; later samples are ignored until reset.
- Reset has priority over obs_vld in the same cycle. Reset mid-stream discards all history.

Optional Feature:
- FSM_OBS_RESYNC_EN defined:
  - An empty result loads cand=5'b11111 (not 0) and err pulses high for exactly one cycle.
  - The next valid sample is processed normally, so the observer re-acquires lock.
- Macro undefined: err is sticky as described in Behaviour.

Decomposition:
- Shared package fsm_obs_pkg holds:
  - state index constants S0_IDX..S4_IDX;
  - one-cold codes S0_ST..S4_ST (01111, 10111, 11011, 11101, 11110);
  - a typedef for the 5-bit candidate set;
  - CAND_ALL = 5'b11111.
- One combinational sub-module fsm_obs_step: per-state next-set plus implied a/b with known masks, instantiated once per state (5x).
- The top level ORs the five next sets and merges the a/b known masks.

Test Plan:
- Lock tracking, INIT_ALL=0: after reset, valid mn = 01, 11, 10, 00, 01.
  - cand = 00010, 00100, 01000, 11000, 10000.
  - a_known/a_rec = 1/1, 0, 1/1, 1/1, 0.
  - b_known/b_rec = 1/0, 0, 0, 0, 1/0.
  - locked = 1,1,1,0,1.
- Hold: obs_vld=0 for 3 cycles with random m/n -> all outputs unchanged.
- Error, macro off:
  - From reset, mn=11 -> next cycle err=1, cand=0, locked=0, cur_st=11111.
  - Further mn=00 samples -> err stays 1.
- INIT_ALL=1: reset then mn=11 -> cand=01111, locked=0, a_known=0, b_known=0.
- Sync reset mid-stream: from locked S3, drop rst_b for one edge with obs_vld=1 -> cand=00001 and sample ignored. A reset that deasserts between edges has no effect.
- FSM_OBS_RESYNC_EN defined: from reset, mn=11 -> err=1 for one cycle, cand=11111. Then mn=10 -> err=0, cand=11000.
